// File: rtl/fuzz_stim_compare_if.sv
// Bus between the stimulus player and the two DUTs under comparison.
// The player drives stim; both DUT outputs come back side by side.
interface fuzz_stim_compare_if #(
    parameter int IN_W  = 254,
    parameter int OUT_W = 376
);
    logic [IN_W-1:0]  stim;
    logic [OUT_W-1:0] y_ref;
    logic [OUT_W-1:0] y_dut;

    modport master (
        output stim,
        input  y_ref,
        input  y_dut
    );

    modport slave (
        input  stim,
        output y_ref,
        output y_dut
    );
endinterface

// File: rtl/fuzz_stim_compare.sv
// Stimulus player and differential checker: applies memory or LFSR
// vectors to two DUTs, MISR-compresses both outputs, flags first diff.
module fuzz_stim_compare #(
    parameter int              IN_W             = 254,
    parameter int              OUT_W            = 376,
    parameter int              DEPTH            = 32,
    parameter int              HOLD             = 1,
    parameter logic [IN_W-1:0] TAPS             = IN_W'('hB8),
    parameter logic [31:0]     POLY             = 32'h04C11DB7,
    parameter bit              STOP_ON_MISMATCH = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [15:0]              num_vec,
    input  logic [IN_W-1:0]          seed,
    input  logic                     load_we,
    input  logic [$clog2(DEPTH)-1:0] load_addr,
    input  logic [IN_W-1:0]          load_data,
    fuzz_stim_compare_if.master      bus,
    output logic                     busy,
    output logic                     done,
    output logic                     mismatch,
    output logic [15:0]              mismatch_idx,
    output logic [15:0]              vec_idx,
    output logic [31:0]              sig_ref,
    output logic [31:0]              sig_dut
);

    localparam int AW  = $clog2(DEPTH);
    localparam int HW  = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int NCH = (OUT_W + 31) / 32;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        FINISH
    } state_t;

    state_t state_q, state_n;

    logic [IN_W-1:0] mem [DEPTH];

    logic [IN_W-1:0] stim_q, stim_n;
    logic            busy_n, done_n, mis_n;
    logic [15:0]     midx_n, vidx_n;
    logic [31:0]     sr_n, sd_n;
    logic [HW-1:0]   hold_q, hold_n;
    logic [15:0]     tot_q, tot_n;
    logic            mode_q, mode_n;
    logic [AW-1:0]   rd_q, rd_n, rd_nxt;

    logic [15:0]     nv;
    logic [IN_W-1:0] vec0;
    logic [IN_W-1:0] lfsr_nxt;
    logic            differ;

    // XOR of all 32-bit chunks, top chunk zero-padded
    function automatic logic [31:0] fold(input logic [OUT_W-1:0] y);
        logic [NCH*32-1:0] p;
        logic [31:0]       f;
        p = '0;
        p[OUT_W-1:0] = y;
        f = '0;
        for (int i = 0; i < NCH; i++) begin
            f = f ^ p[i*32 +: 32];
        end
        return f;
    endfunction

    function automatic logic [31:0] misr(
        input logic [31:0]      s,
        input logic [OUT_W-1:0] y
    );
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ fold(y);
    endfunction

    assign nv = (!mode && num_vec > 16'(DEPTH)) ? 16'(DEPTH) : num_vec;

    // Same-cycle write to entry 0 must be visible to a run starting now
    assign vec0 = mode ? ((seed == '0) ? IN_W'(1) : seed)
                       : ((load_we && load_addr == '0) ? load_data : mem[0]);

    assign lfsr_nxt = {stim_q[IN_W-2:0], ^(stim_q & TAPS)};
    assign rd_nxt   = rd_q + 1'b1;
    assign differ   = bus.y_ref != bus.y_dut;
    assign bus.stim = stim_q;

    // Vector memory: loadable whenever no run is in progress
    always_ff @(posedge clk) begin
        if (load_we && state_q != APPLY) begin
            mem[load_addr] <= load_data;
        end
    end

    // Next-state, vector sequencing, signature and mismatch tracking
    always_comb begin
        state_n = state_q;
        stim_n  = stim_q;
        busy_n  = busy;
        done_n  = done;
        mis_n   = mismatch;
        midx_n  = mismatch_idx;
        vidx_n  = vec_idx;
        sr_n    = sig_ref;
        sd_n    = sig_dut;
        hold_n  = hold_q;
        tot_n   = tot_q;
        mode_n  = mode_q;
        rd_n    = rd_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_n   = '0;
                    sd_n   = '0;
                    mis_n  = 1'b0;
                    midx_n = '0;
                    done_n = 1'b0;
                    if (nv == 16'd0) begin
                        done_n  = 1'b1;
                        state_n = FINISH;
                    end else begin
                        state_n = APPLY;
                        busy_n  = 1'b1;
                        stim_n  = vec0;
                        vidx_n  = '0;
                        hold_n  = '0;
                        tot_n   = nv;
                        mode_n  = mode;
                        rd_n    = '0;
                    end
                end
            end
            APPLY: begin
                if (hold_q == HW'(HOLD - 1)) begin
                    sr_n = misr(sig_ref, bus.y_ref);
                    sd_n = misr(sig_dut, bus.y_dut);
                    if (differ && !mismatch) begin
                        mis_n  = 1'b1;
                        midx_n = vec_idx;
                    end
                    if (vec_idx == tot_q - 16'd1 ||
                        (STOP_ON_MISMATCH && differ)) begin
                        state_n = FINISH;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        stim_n  = '0;
                    end else begin
                        vidx_n = vec_idx + 16'd1;
                        hold_n = '0;
                        rd_n   = rd_nxt;
                        stim_n = mode_q ? lfsr_nxt : mem[rd_nxt];
                    end
                end else begin
                    hold_n = hold_q + 1'b1;
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            stim_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            mismatch     <= 1'b0;
            mismatch_idx <= '0;
            vec_idx      <= '0;
            sig_ref      <= '0;
            sig_dut      <= '0;
            hold_q       <= '0;
            tot_q        <= '0;
            mode_q       <= 1'b0;
            rd_q         <= '0;
        end else begin
            state_q      <= state_n;
            stim_q       <= stim_n;
            busy         <= busy_n;
            done         <= done_n;
            mismatch     <= mis_n;
            mismatch_idx <= midx_n;
            vec_idx      <= vidx_n;
            sig_ref      <= sr_n;
            sig_dut      <= sd_n;
            hold_q       <= hold_n;
            tot_q        <= tot_n;
            mode_q       <= mode_n;
            rd_q         <= rd_n;
        end
    end

endmodule

// File: tb/tb_fuzz_stim_compare.sv
// Scoreboard bench for fuzz_stim_compare: two instances, one with
// early stop on mismatch, checked against hand-computed vectors.
module tb_fuzz_stim_compare;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic [15:0] num_vec;
    logic [7:0]  seed;
    logic        load_we;
    logic [1:0]  load_addr;
    logic [7:0]  load_data;
    logic        corrupt;

    logic        busy0, done0, mis0, busy1, done1, mis1;
    logic [15:0] midx0, vidx0, midx1, vidx1;
    logic [31:0] sr0, sd0, sr1, sd1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0]  stim;
        logic [15:0] idx;
        logic [31:0] sr;
        logic [31:0] sd;
    } vec_t;

    typedef struct {
        logic        mis;
        logic [15:0] midx;
        logic [31:0] sr;
        logic [31:0] sd;
        logic [15:0] vidx;
    } res_t;

    vec_t vq0[$], vq1[$];
    res_t rq0[$], rq1[$];

    always #5 clk = ~clk;

    fuzz_stim_compare_if #(.IN_W(8), .OUT_W(8)) bus0 ();
    fuzz_stim_compare_if #(.IN_W(8), .OUT_W(8)) bus1 ();

    assign bus0.y_ref = bus0.stim;
    assign bus0.y_dut = bus0.stim ^ {7'b0, corrupt && bus0.stim == 8'hF0};
    assign bus1.y_ref = bus1.stim;
    assign bus1.y_dut = bus1.stim ^ {7'b0, corrupt && bus1.stim == 8'hF0};

    fuzz_stim_compare #(
        .IN_W(8), .OUT_W(8), .DEPTH(4), .HOLD(1),
        .TAPS(8'hB8), .STOP_ON_MISMATCH(1'b0)
    ) u0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .num_vec(num_vec), .seed(seed), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .bus(bus0),
        .busy(busy0), .done(done0), .mismatch(mis0),
        .mismatch_idx(midx0), .vec_idx(vidx0),
        .sig_ref(sr0), .sig_dut(sd0)
    );

    fuzz_stim_compare #(
        .IN_W(8), .OUT_W(8), .DEPTH(4), .HOLD(1),
        .TAPS(8'hB8), .STOP_ON_MISMATCH(1'b1)
    ) u1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .num_vec(num_vec), .seed(seed), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .bus(bus1),
        .busy(busy1), .done(done1), .mismatch(mis1),
        .mismatch_idx(midx1), .vec_idx(vidx1),
        .sig_ref(sr1), .sig_dut(sd1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_v(input logic [7:0] s, input logic [15:0] i,
                          input logic [31:0] r, input logic [31:0] d,
                          input bit both);
        vec_t v;
        v.stim = s; v.idx = i; v.sr = r; v.sd = d;
        vq0.push_back(v);
        if (both) vq1.push_back(v);
    endtask

    task automatic push_r(input logic m, input logic [15:0] mi,
                          input logic [31:0] r, input logic [31:0] d,
                          input logic [15:0] vi, input int which);
        res_t x;
        x.mis = m; x.midx = mi; x.sr = r; x.sd = d; x.vidx = vi;
        if (which != 1) rq0.push_back(x);
        if (which != 0) rq1.push_back(x);
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!(done0 && done1) && k < 40) begin
            cyc();
            k++;
        end
        if (!(done0 && done1)) fail({nm, " timeout waiting for done"});
        cyc();
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " stim"}, 32'(bus0.stim), 32'h0);
        chk({nm, " busy"}, 32'(busy0), 32'h0);
        chk({nm, " done"}, 32'(done0), 32'h0);
        chk({nm, " mismatch"}, 32'(mis0), 32'h0);
        chk({nm, " midx"}, 32'(midx0), 32'h0);
        chk({nm, " vec_idx"}, 32'(vidx0), 32'h0);
        chk({nm, " sig_ref"}, sr0, 32'h0);
        chk({nm, " sig_dut"}, sd0, 32'h0);
        chk({nm, " u1 busy"}, 32'(busy1), 32'h0);
        chk({nm, " u1 vec_idx"}, 32'(vidx1), 32'h0);
    endtask

    logic done0_d = 1'b0;
    logic done1_d = 1'b0;
    vec_t mv0, mv1;
    res_t mr0, mr1;

    // Monitor for the free-running instance
    always @(negedge clk) begin
        if (busy0) begin
            if (vq0.size() == 0) begin
                fail("u0 unexpected busy cycle");
            end else begin
                mv0 = vq0.pop_front();
                chk("u0 stim", 32'(bus0.stim), 32'(mv0.stim));
                chk("u0 vec_idx", 32'(vidx0), 32'(mv0.idx));
                chk("u0 sig_ref", sr0, mv0.sr);
                chk("u0 sig_dut", sd0, mv0.sd);
            end
        end
        if (done0 && !done0_d) begin
            if (rq0.size() == 0) begin
                fail("u0 unexpected done");
            end else begin
                mr0 = rq0.pop_front();
                chk("u0 res mismatch", 32'(mis0), 32'(mr0.mis));
                chk("u0 res midx", 32'(midx0), 32'(mr0.midx));
                chk("u0 res sig_ref", sr0, mr0.sr);
                chk("u0 res sig_dut", sd0, mr0.sd);
                chk("u0 res vec_idx", 32'(vidx0), 32'(mr0.vidx));
                chk("u0 res stim", 32'(bus0.stim), 32'h0);
            end
        end
        done0_d = done0;
    end

    // Monitor for the stop-on-mismatch instance
    always @(negedge clk) begin
        if (busy1) begin
            if (vq1.size() == 0) begin
                fail("u1 unexpected busy cycle");
            end else begin
                mv1 = vq1.pop_front();
                chk("u1 stim", 32'(bus1.stim), 32'(mv1.stim));
                chk("u1 vec_idx", 32'(vidx1), 32'(mv1.idx));
                chk("u1 sig_ref", sr1, mv1.sr);
                chk("u1 sig_dut", sd1, mv1.sd);
            end
        end
        if (done1 && !done1_d) begin
            if (rq1.size() == 0) begin
                fail("u1 unexpected done");
            end else begin
                mr1 = rq1.pop_front();
                chk("u1 res mismatch", 32'(mis1), 32'(mr1.mis));
                chk("u1 res midx", 32'(midx1), 32'(mr1.midx));
                chk("u1 res sig_ref", sr1, mr1.sr);
                chk("u1 res sig_dut", sd1, mr1.sd);
                chk("u1 res vec_idx", 32'(vidx1), 32'(mr1.vidx));
                chk("u1 res stim", 32'(bus1.stim), 32'h0);
            end
        end
        done1_d = done1;
    end

    // Directed stimulus sequence
    initial begin
        logic [7:0] memv [4];
        memv[0] = 8'hAA; memv[1] = 8'h55;
        memv[2] = 8'hF0; memv[3] = 8'h0F;
        rst = 1'b1; start = 1'b0; mode = 1'b0; num_vec = '0;
        seed = '0; load_we = 1'b0; load_addr = '0; load_data = '0;
        corrupt = 1'b0;
        repeat (3) cyc();
        chk_reset("reset");
        rst = 1'b0;
        cyc();

        // num_vec = 0: done next cycle, no samples
        push_r(1'b0, 16'd0, 32'h0, 32'h0, 16'd0, 2);
        num_vec = 16'd0; start = 1'b1;
        cyc();
        start = 1'b0;
        chk("nv0 done", 32'(done0), 32'h1);
        chk("nv0 busy", 32'(busy0), 32'h0);
        cyc();

        for (int i = 0; i < 4; i++) begin
            load_we = 1'b1; load_addr = 2'(i); load_data = memv[i];
            cyc();
        end
        load_we = 1'b0;

        // LFSR run, with a stray start mid-run
        push_v(8'h01, 16'd0, 32'h00, 32'h00, 1'b1);
        push_v(8'h02, 16'd1, 32'h01, 32'h01, 1'b1);
        push_v(8'h04, 16'd2, 32'h00, 32'h00, 1'b1);
        push_v(8'h08, 16'd3, 32'h04, 32'h04, 1'b1);
        push_v(8'h11, 16'd4, 32'h00, 32'h00, 1'b1);
        push_r(1'b0, 16'd0, 32'h11, 32'h11, 16'd4, 2);
        mode = 1'b1; seed = 8'h01; num_vec = 16'd5; start = 1'b1;
        cyc();
        start = 1'b0; mode = 1'b0; num_vec = 16'd2;
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done("lfsr");

        // Memory run with vector 2 corrupted on the DUT side
        corrupt = 1'b1;
        push_v(8'hAA, 16'd0, 32'h000, 32'h000, 1'b1);
        push_v(8'h55, 16'd1, 32'h0AA, 32'h0AA, 1'b1);
        push_v(8'hF0, 16'd2, 32'h101, 32'h101, 1'b1);
        push_v(8'h0F, 16'd3, 32'h2F2, 32'h2F3, 1'b0);
        push_r(1'b1, 16'd2, 32'h5EB, 32'h5E9, 16'd3, 0);
        push_r(1'b1, 16'd2, 32'h2F2, 32'h2F3, 16'd2, 1);
        mode = 1'b0; num_vec = 16'd4; start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done("mem mismatch");
        corrupt = 1'b0;

        // num_vec clamped to DEPTH; write during run ignored
        push_v(8'hAA, 16'd0, 32'h000, 32'h000, 1'b1);
        push_v(8'h55, 16'd1, 32'h0AA, 32'h0AA, 1'b1);
        push_v(8'hF0, 16'd2, 32'h101, 32'h101, 1'b1);
        push_v(8'h0F, 16'd3, 32'h2F2, 32'h2F2, 1'b1);
        push_r(1'b0, 16'd0, 32'h5EB, 32'h5EB, 16'd3, 2);
        num_vec = 16'd9; start = 1'b1;
        cyc();
        start = 1'b0;
        load_we = 1'b1; load_addr = 2'd3; load_data = 8'h77;
        cyc();
        load_we = 1'b0;
        wait_done("clamp");

        // seed of zero starts at 01
        push_v(8'h01, 16'd0, 32'h0, 32'h0, 1'b1);
        push_r(1'b0, 16'd0, 32'h1, 32'h1, 16'd0, 2);
        mode = 1'b1; seed = 8'h00; num_vec = 16'd1; start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done("seed0");

        // load and start in the same cycle
        push_v(8'h3C, 16'd0, 32'h0, 32'h0, 1'b1);
        push_r(1'b0, 16'd0, 32'h3C, 32'h3C, 16'd0, 2);
        mode = 1'b0; num_vec = 16'd1; start = 1'b1;
        load_we = 1'b1; load_addr = 2'd0; load_data = 8'h3C;
        cyc();
        start = 1'b0; load_we = 1'b0;
        wait_done("load+start");

        // reset while vector 1 is applied
        push_v(8'h01, 16'd0, 32'h0, 32'h0, 1'b1);
        push_v(8'h02, 16'd1, 32'h1, 32'h1, 1'b1);
        mode = 1'b1; seed = 8'h01; num_vec = 16'd5; start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk_reset("midrun reset");
        rst = 1'b0;
        repeat (2) cyc();

        chk("vq0 leftover", 32'(vq0.size()), 32'h0);
        chk("vq1 leftover", 32'(vq1.size()), 32'h0);
        chk("rq0 leftover", 32'(rq0.size()), 32'h0);
        chk("rq1 leftover", 32'(rq1.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fuzz_stim_compare.md
Name: fuzz_stim_compare

Overview:
Synthesizable stimulus player and differential checker for fuzz equivalence runs. It drives one packed input vector onto two DUT instances in parallel, a reference netlist and a synthesized netlist, and holds each vector for HOLD cycles. On every vector it samples both DUT outputs, compresses each into a 32-bit MISR signature, and flags the first differing vector. It generalises the fixed-width, fixed-list clock/strobe bench: width, depth, hold time and vector source (loaded memory or LFSR) are all configurable.

Parameters:
IN_W, 254, width of the packed DUT input bus (stim).
OUT_W, 376, width of each DUT output bus.
DEPTH, 32, number of vector-memory entries.
HOLD, 1, cycles each vector is applied; must be >= 1.
TAPS, {IN_W{1'b0}} | 'hB8, LFSR feedback mask.
POLY, 32'h04C11DB7, MISR polynomial.
STOP_ON_MISMATCH, 0, 1 = end the run at the first mismatch.

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
start  in  1  1-cycle pulse that begins a run; honoured only in IDLE.
mode  in  1  0 = vectors from memory, 1 = vectors from LFSR; sampled at start.
num_vec  in  $clog2(DEPTH+1) (mode 0) / 16 (mode 1), use 16  number of vectors to apply.
seed  in  IN_W  LFSR seed; sampled at start.
load_we  in  1  memory write enable; ignored while busy.
load_addr  in  $clog2(DEPTH)  memory write address.
load_data  in  IN_W  memory write data.
stim  out  IN_W  registered vector driven to both DUTs.
y_ref  in  OUT_W  reference DUT output.
y_dut  in  OUT_W  synthesized DUT output.
busy  out  1  high during a run.
done  out  1  high from run end until the next start or rst.
mismatch  out  1  sticky; set on the first differing sample.
mismatch_idx  out  16  index of the first differing vector.
vec_idx  out  16  index of the vector currently applied.
sig_ref  out  32  MISR signature of y_ref.
sig_dut  out  32  MISR signature of y_dut.

Behaviour:
- Reset: stim=0, busy=0, done=0, mismatch=0, mismatch_idx=0, vec_idx=0, sig_ref=sig_dut=0, FSM=IDLE, LFSR=0. rst asserted mid-run aborts the run immediately. Memory contents are not reset.
- FSM states: IDLE -> APPLY -> (SAMPLE folded into the last hold cycle) -> FINISH -> IDLE.
- IDLE + start (cycle t): clear sigs, mismatch, mismatch_idx and done.
  - num_vec==0: done=1 at t+1, busy stays 0, no samples taken.
  - Otherwise: at t+1 stim=vector 0, vec_idx=0, busy=1.
- Vector source:
  - mode 0: vector k = mem[k]. num_vec is clamped to DEPTH.
  - mode 1: vector 0 = seed, or 1 if seed==0. Next vector = {v[IN_W-2:0], ^(v & TAPS)}.
- Hold and sample: each vector stays on stim for HOLD cycles. On the clock edge that ends the HOLD-th cycle, y_ref and y_dut are sampled; the next vector (or FINISH) takes effect at that same edge.
- MISR update: fold(y) = XOR of the 32-bit chunks of y, with the top chunk zero-padded. Then sig <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold(y), applied to both channels in the same cycle.
- Mismatch: if y_ref != y_dut (full width) and mismatch==0, then mismatch<=1 and mismatch_idx<=vec_idx. If STOP_ON_MISMATCH=1, go to FINISH after that sample.
- FINISH: one cycle with busy=0, done=1, stim=0, FSM=IDLE. done holds until the next start or rst.
- start while busy is ignored. load_we while busy is ignored. load_we and start in the same IDLE cycle: the write happens and the run reads the updated memory.
- Run length: total busy cycles = num_vec*HOLD when no early stop.

Test Plan:
(Bench parameters: IN_W=8, OUT_W=8, DEPTH=4, HOLD=1, TAPS=8'hB8.)
- LFSR sequence: mode 1, seed=8'h01, num_vec=5 -> stim sequence 01,02,04,08,11 on consecutive cycles; busy high 5 cycles; then done=1 and stim=0.
- Identical DUTs: y_ref=y_dut=stim -> sig_ref==sig_dut, mismatch=0. After vector 01 the sig is 32'h00000001; after vector 02 it is 32'h00000000 (2^2).
- Memory mismatch: load mem={AA,55,F0,0F}, mode 0, num_vec=4, y_dut=stim except vector 2 corrupted to F1 -> mismatch=1, mismatch_idx=2, sig_ref!=sig_dut.
- Early stop: same stimulus with STOP_ON_MISMATCH=1 -> busy drops after the vector-2 sample; vec_idx never reaches 3.
- Boundaries: num_vec=0 -> done the cycle after start, sigs=0. num_vec=9 in mode 0 -> exactly 4 vectors applied. seed=0 -> first stim=01.
- Reset and ignored inputs: rst asserted at vector 1 -> the next cycle shows all outputs at reset values. A start pulse during a run is ignored. A load_we during a run leaves memory unchanged.
